// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MIPS multiply/divide unit owning the HI/LO registers
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   localparam logic [2:0] OP_MTHI = 3'd4;
   localparam logic [2:0] OP_MTLO = 3'd5;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   logic [1:0]         r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [2*WIDTH-1:0] r_p;
   logic [WIDTH-1:0]   r_m;
   logic               r_div;
   logic               r_neg_q;
   logic               r_neg_r;
   logic               r_dz;
   logic               r_done;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;

   logic               w_signed;
   logic [WIDTH-1:0]   w_abs_a;
   logic [WIDTH-1:0]   w_abs_b;
   logic [WIDTH:0]     w_madd;
   logic [2*WIDTH-1:0] w_mstep;
   logic [WIDTH:0]     w_dtop;
   logic               w_dok;
   logic [WIDTH-1:0]   w_drem;
   logic [2*WIDTH-1:0] w_dstep;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;

   // MULT and DIV are the even encodings among ops 0-3.
   assign w_signed = ~op[0];
   assign w_abs_a  = (w_signed && A[WIDTH-1]) ? -A : A;
   assign w_abs_b  = (w_signed && B[WIDTH-1]) ? -B : B;

   // Shift-add: r_p = {partial product, remaining multiplier bits}.
   assign w_madd  = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});
   assign w_mstep = {w_madd, r_p[WIDTH-1:1]};

   // Restoring divide: r_p = {remainder, dividend bits shifting into quotient}.
   assign w_dtop  = r_p[2*WIDTH-1:WIDTH-1];
   assign w_dok   = (w_dtop >= {1'b0, r_m});
   assign w_drem  = w_dtop[WIDTH-1:0] - r_m;
   assign w_dstep = {(w_dok ? w_drem : w_dtop[WIDTH-1:0]), r_p[WIDTH-2:0], w_dok};

   // A zero divisor leaves the dividend as remainder; only the quotient needs forcing.
   assign w_prod = r_neg_q ? -r_p : r_p;
   assign w_quo  = r_dz ? {WIDTH{1'b1}} : (r_neg_q ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0]);
   assign w_rem  = r_neg_r ? -r_p[2*WIDTH-1:WIDTH] : r_p[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_p     <= '0;
         r_m     <= '0;
         r_div   <= 1'b0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_dz    <= 1'b0;
         r_done  <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (!op[2]) begin
                     r_state <= S_RUN;
                     r_cnt   <= '0;
                     r_div   <= op[1];
                     r_m     <= op[1] ? w_abs_b : w_abs_a;
                     r_p     <= {{WIDTH{1'b0}}, (op[1] ? w_abs_a : w_abs_b)};
                     r_neg_q <= w_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                     r_neg_r <= w_signed & A[WIDTH-1];
                     r_dz    <= op[1] & (B == '0);
                  end else if (op == OP_MTHI) begin
                     r_hi <= A;
                  end else if (op == OP_MTLO) begin
                     r_lo <= A;
                  end
               end
            end
            S_RUN: begin
               r_p   <= r_div ? w_dstep : w_mstep;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CNT_LAST) begin
                  r_state <= S_FIX;
               end
            end
            S_FIX: begin
               if (r_div) begin
                  r_hi <= w_rem;
                  r_lo <= w_quo;
               end else begin
                  r_hi <= w_prod[2*WIDTH-1:WIDTH];
                  r_lo <= w_prod[WIDTH-1:0];
               end
               r_done  <= 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy = (r_state != S_IDLE);
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed vector bench for muldiv_unit
module tb_muldiv_unit;
   localparam int W = 32;

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [2:0]   op = 3'd0;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int n_pass = 0;
   int n_total = 0;
   int lat;
   int glitch;
   vec_t vecs[10];

   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(W), .CNT_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
   endtask

   task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input bit now);
      if (!now) @(negedge clk);
      op = o; A = a; B = b; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Counts edges after the accept edge until done; optionally pulses start at edge inj.
   task automatic wait_done(input int inj, input logic [2:0] io, input logic [W-1:0] ia,
                            input logic [W-1:0] ib, output int l, output int g);
      logic [W-1:0] h0, l0;
      h0 = hi; l0 = lo; l = 0; g = 0;
      while (l < 40) begin
         @(posedge clk);
         #1 l++;
         if (done) break;
         if (!busy || hi !== h0 || lo !== l0) g++;
         if (l == inj) begin op = io; A = ia; B = ib; start = 1'b1; end
         else start = 1'b0;
      end
      start = 1'b0;
   endtask

   initial begin
      vecs[0] = '{3'd1, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE};
      vecs[1] = '{3'd0, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE};
      vecs[2] = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3] = '{3'd3, 32'd100,      32'd7,        32'd2,        32'd14};
      vecs[4] = '{3'd3, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
      vecs[5] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[6] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vecs[7] = '{3'd2, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
      vecs[8] = '{3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
      vecs[9] = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};

      #1;
      chk("rst_hi", hi, 32'h0);
      chk("rst_lo", lo, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'h0);
      chk("rst_done", {31'b0, done}, 32'h0);
      @(negedge clk) rst_n = 1'b1;

      issue(3'd4, 32'h12345678, 32'h0, 1'b0);
      chk("mthi_hi", hi, 32'h12345678);
      chk("mthi_busy", {31'b0, busy}, 32'h0);
      chk("mthi_done", {31'b0, done}, 32'h0);
      issue(3'd5, 32'hCAFEBABE, 32'h0, 1'b0);
      chk("mtlo_lo", lo, 32'hCAFEBABE);
      chk("mtlo_hi", hi, 32'h12345678);
      @(posedge clk) #1;
      chk("mtlo_busy_later", {31'b0, busy}, 32'h0);
      issue(3'd6, 32'hDEADBEEF, 32'h1, 1'b0);
      chk("nop_hi", hi, 32'h12345678);
      chk("nop_lo", lo, 32'hCAFEBABE);
      chk("nop_busy", {31'b0, busy}, 32'h0);

      for (int i = 0; i < 10; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
         chk($sformatf("v%0d_busy_start", i), {31'b0, busy}, 32'h1);
         wait_done(-1, 3'd0, '0, '0, lat, glitch);
         chk($sformatf("v%0d_latency", i), 32'(lat), 32'd33);
         chk($sformatf("v%0d_run_hold", i), 32'(glitch), 32'd0);
         chk($sformatf("v%0d_busy_done", i), {31'b0, busy}, 32'h0);
         chk($sformatf("v%0d_hi", i), hi, vecs[i].hi);
         chk($sformatf("v%0d_lo", i), lo, vecs[i].lo);
         @(posedge clk) #1;
         chk($sformatf("v%0d_done_pulse", i), {31'b0, done}, 32'h0);
      end

      // Start pulsed mid-run with other operands must be ignored.
      issue(3'd3, 32'd100, 32'd7, 1'b0);
      wait_done(5, 3'd1, 32'd9, 32'd9, lat, glitch);
      chk("midrun_latency", 32'(lat), 32'd33);
      chk("midrun_hold", 32'(glitch), 32'd0);
      chk("midrun_hi", hi, 32'd2);
      chk("midrun_lo", lo, 32'd14);

      // Back-to-back: new start issued in the done cycle.
      issue(3'd1, 32'hFFFFFFFF, 32'd2, 1'b1);
      chk("b2b_busy", {31'b0, busy}, 32'h1);
      wait_done(-1, 3'd0, '0, '0, lat, glitch);
      chk("b2b_latency", 32'(lat), 32'd33);
      chk("b2b_hi", hi, 32'h00000001);
      chk("b2b_lo", lo, 32'hFFFFFFFE);

      // Asynchronous reset in the middle of a divide.
      issue(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
      repeat (10) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_busy", {31'b0, busy}, 32'h0);
      chk("arst_hi", hi, 32'h0);
      chk("arst_lo", lo, 32'h0);
      chk("arst_done", {31'b0, done}, 32'h0);
      @(negedge clk) rst_n = 1'b1;
      issue(3'd1, 32'd3, 32'd4, 1'b0);
      wait_done(-1, 3'd0, '0, '0, lat, glitch);
      chk("post_rst_latency", 32'(lat), 32'd33);
      chk("post_rst_hi", hi, 32'd0);
      chk("post_rst_lo", lo, 32'd12);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
